rand_prefetch: RTL

RAND_PREFETCH -- requirements
Module: rand_prefetch

---
 rtl/rand_prefetch.sv | 134 +++++++++++++
 1 files changed

// File: rtl/rand_prefetch.sv
// Random-number prefetch buffer: keeps a DEPTH-entry FIFO topped up from a request/response PRNG.
// Optional macro RAND_PREFETCH_NODUP_EN discards a response equal to the last pushed value.
module rand_prefetch #(
  parameter int OUTPUT_SIZE = 4,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic                     clk,
  input  logic                     resetn,
  output logic                     prng_next,
  input  logic                     prng_valid,
  input  logic [OUTPUT_SIZE-1:0]   prng_number,
  input  logic                     flush,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [OUTPUT_SIZE-1:0]   rd_data,
  output logic [$clog2(DEPTH):0]   fill_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  state_t                 state, state_nxt;
  logic [TW-1:0]          tmo, tmo_nxt;
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [OUTPUT_SIZE-1:0] mem [DEPTH];
  logic                   push, pop, dup;

`ifdef RAND_PREFETCH_NODUP_EN
  logic [OUTPUT_SIZE-1:0] last_val;
  logic                   last_vld;

  assign dup = last_vld && (prng_number == last_val);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_val <= '0;
      last_vld <= 1'b0;
    end else if (flush) begin
      last_val <= '0;
      last_vld <= 1'b0;
    end else if (push) begin
      last_val <= prng_number;
      last_vld <= 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  assign prng_next = (state == REQ);
  assign rd_valid  = (fill_level != '0);
  assign rd_data   = rd_valid ? mem[rd_ptr] : '0;
  assign pop       = rd_valid && rd_ready && !flush;

  always_comb begin
    state_nxt = state;
    tmo_nxt   = tmo;
    push      = 1'b0;
    case (state)
      IDLE: if (fill_level < FULL_LVL) state_nxt = REQ;
      REQ: begin
        state_nxt = WAIT;
        tmo_nxt   = '0;
      end
      WAIT: begin
        if (prng_valid) begin
          tmo_nxt = '0;
          if (dup) begin
            state_nxt = REQ;
          end else begin
            push      = 1'b1;
            state_nxt = IDLE;
          end
        end else if (tmo == TMO_LAST) begin
          tmo_nxt   = '0;
          state_nxt = REQ;
        end else begin
          tmo_nxt = tmo + TW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Flush overrides everything, including a response landing this cycle.
    if (flush) begin
      state_nxt = IDLE;
      tmo_nxt   = '0;
      push      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      tmo   <= '0;
    end else begin
      state <= state_nxt;
      tmo   <= tmo_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fill_level <= fill_level + (AW+1)'(1);
        2'b01:   fill_level <= fill_level - (AW+1)'(1);
        default: fill_level <= fill_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= prng_number;
  end

endmodule
